polyphase_fir_decimator: RTL and testbench

- Parametrised successor to the single-rate golden FIR filter: a streaming real-valued FIR with integer decimation and run-time loadable coefficients.
- Accepts one signed sample per `valid_in` strobe and keeps a TAPS-deep delay line.
- Emits one rounded, saturated output for every DECIM accepted inputs.
- Sits in the polyphase front end, ahead of the channelizer; the golden model is reused as the reference for DECIM=1.

---
 rtl/polyphase_fir_decimator.sv | 149 ++++++++++++++
 tb/tb_polyphase_fir_decimator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_fir_decimator.sv
// Streaming FIR decimator: TAPS-deep delay line, run-time coefficients, one
// rounded and saturated output for every DECIM accepted samples.
module polyphase_fir_decimator #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int TAPS   = 16,
    parameter int DECIM  = 4,
    parameter int FRAC   = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic signed [DATA_W-1:0]  data_in,
    input  logic                      valid_in,
    input  logic                      sync_clr,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic signed [OUT_W-1:0]   data_out,
    output logic                      valid_out
);

    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [AW:0]     TAPS_L  = (AW + 1)'(TAPS);

    localparam logic signed [ACC_W:0] RND_HALF =
        {{(ACC_W - FRAC + 1){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    // Half-up rounding: bias by half an output LSB, then floor via arithmetic shift.
    function automatic logic signed [ACC_W:0] round_half_up(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W:0] wide;
        wide = $signed({a[ACC_W-1], a});
        return (wide + RND_HALF) >>> FRAC;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(
        input logic signed [ACC_W:0] r
    );
        if (r > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return r[OUT_W-1:0];
    endfunction

    logic signed [COEF_W-1:0] coef    [TAPS];
    logic signed [DATA_W-1:0] dly     [TAPS-1];
    logic signed [DATA_W-1:0] x_p0    [TAPS];
    logic signed [PROD_W-1:0] prod_p1 [TAPS];
    logic signed [ACC_W-1:0]  acc_p1;
    logic [PH_W-1:0]          phase;
    logic                     accept_p0;
    logic                     trig_p0;
    logic                     addr_ok;
    logic                     vld_p1;
    logic                     vld_p2;

    assign accept_p0 = valid_in && !sync_clr;
    assign trig_p0   = accept_p0 && (phase == PH_LAST);
    assign addr_ok   = ({1'b0, coef_addr} < TAPS_L);

    // Products are taken from the line as it will look after this edge's shift.
    always_comb begin
        x_p0[0] = data_in;
        for (int k = 1; k < TAPS; k++) begin
            x_p0[k] = dly[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
            end
        end else if (coef_we && addr_ok) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // ---- stage 0: delay line and decimation phase ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                dly[k] <= '0;
            end
            phase <= '0;
        end else if (sync_clr) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                dly[k] <= '0;
            end
            phase <= '0;
        end else if (valid_in) begin
            dly[0] <= data_in;
            for (int k = 1; k < TAPS - 1; k++) begin
                dly[k] <= dly[k-1];
            end
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    // ---- stage 1: full-precision tap products ----
    always_ff @(posedge clk) begin
        if (trig_p0) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_p1[k] <= PROD_W'(coef[k]) * PROD_W'(x_p0[k]);
            end
        end
    end

    always_comb begin
        acc_p1 = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_p1 = acc_p1 + ACC_W'(prod_p1[k]);
        end
    end

    // ---- stage 2: sum, round, saturate ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            data_out <= '0;
        end else if (sync_clr) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            data_out <= '0;
        end else begin
            vld_p1 <= trig_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_out <= saturate(round_half_up(acc_p1));
            end
        end
    end

    assign valid_out = vld_p2;

endmodule

// File: tb/tb_polyphase_fir_decimator.sv
// Bench for polyphase_fir_decimator: a DECIM=4 and a DECIM=1 build share one
// stimulus stream and are compared every cycle against a behavioural FIR model.
module tb_polyphase_fir_decimator;

    localparam int TAPS = 16;
    localparam int FRAC = 15;

    logic               clk = 1'b0;
    logic               reset_n;
    logic signed [15:0] data_in;
    logic               valid_in;
    logic               sync_clr;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic signed [15:0] d4_out;
    logic               d4_vld;
    logic signed [15:0] d1_out;
    logic               d1_vld;

    polyphase_fir_decimator #(
        .DATA_W(16), .COEF_W(16), .OUT_W(16), .TAPS(TAPS), .DECIM(4), .FRAC(FRAC)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
        .sync_clr(sync_clr), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .data_out(d4_out), .valid_out(d4_vld)
    );

    polyphase_fir_decimator #(
        .DATA_W(16), .COEF_W(16), .OUT_W(16), .TAPS(TAPS), .DECIM(1), .FRAC(FRAC)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
        .sync_clr(sync_clr), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .data_out(d1_out), .valid_out(d1_vld)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: index 0 models the DECIM=4 build, index 1 the DECIM=1 build.
    int     mdec [2] = '{4, 1};
    longint hist [2][TAPS];
    int     ph   [2];
    longint hc   [TAPS];
    bit     pv   [2];
    longint pd   [2];
    bit     ov   [2];
    longint od   [2];

    longint q4 [$];
    longint q1 [$];
    int     c4 [$];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint golden(input int m);
        longint s;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += hc[k] * hist[m][k];
        s = (s + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < TAPS; k++) hist[m][k] = 0;
            ph[m] = 0; pv[m] = 0; pd[m] = 0; ov[m] = 0; od[m] = 0;
        end
        for (int k = 0; k < TAPS; k++) hc[k] = 0;
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            ov[m] = pv[m];
            if (pv[m]) od[m] = pd[m];
            pv[m] = 0;
            if (sync_clr) begin
                for (int k = 0; k < TAPS; k++) hist[m][k] = 0;
                ph[m] = 0; ov[m] = 0; od[m] = 0;
            end else if (valid_in) begin
                for (int k = TAPS - 1; k > 0; k--) hist[m][k] = hist[m][k-1];
                hist[m][0] = longint'(data_in);
                if (ph[m] == mdec[m] - 1) begin
                    pv[m] = 1;
                    pd[m] = golden(m);
                end
                ph[m] = (ph[m] + 1) % mdec[m];
            end
        end
        if (coef_we && int'(coef_addr) < TAPS) hc[coef_addr] = longint'(coef_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("valid4", d4_vld, ov[0]);
        chk("data4",  d4_out, od[0]);
        chk("valid1", d1_vld, ov[1]);
        chk("data1",  d1_out, od[1]);
        if (d4_vld) begin q4.push_back(d4_out); c4.push_back(cyc); end
        if (d1_vld) q1.push_back(d1_out);
    endtask

    task automatic send(input logic signed [15:0] x);
        data_in = x; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wcoef(input int a, input logic signed [15:0] d);
        coef_we = 1'b1; coef_addr = 4'(a); coef_data = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic clr();
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
    endtask

    task automatic flush();
        repeat (3) tick();
    endtask

    task automatic clearq();
        q4.delete(); q1.delete(); c4.delete();
    endtask

    task automatic boxcar_coefs();
        for (int k = 0; k < TAPS; k++) wcoef(k, (k < 4) ? 16'sh4000 : 16'sh0000);
    endtask

    initial begin
        int s0;
        reset_n = 1'b0; data_in = '0; valid_in = 1'b0; sync_clr = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        #12;
        chk("reset_valid4", d4_vld, 0);
        chk("reset_data4",  d4_out, 0);
        chk("reset_valid1", d1_vld, 0);
        reset_n = 1'b1;

        // Boxcar, dense input
        boxcar_coefs();
        clearq();
        s0 = cyc;
        for (int i = 0; i < 16; i++) send(16'sh1000);
        flush();
        chk("box_count", q4.size(), 4);
        for (int j = 0; j < q4.size() && j < 4; j++) begin
            chk("box_value", q4[j], 16'h2000);
            chk("box_latency", c4[j], s0 + 4 * j + 5);
        end

        // Impulse response through ramp coefficients
        for (int k = 0; k < TAPS; k++) wcoef(k, 16'(k * 256));
        clr();
        clearq();
        send(16'sh7FFF);
        for (int i = 0; i < 15; i++) send(16'sh0000);
        flush();
        chk("imp_count", q4.size(), 4);
        if (q4.size() == 4) begin
            chk("imp_0", q4[0], 768);
            chk("imp_1", q4[1], 1792);
            chk("imp_2", q4[2], 2816);
            chk("imp_3", q4[3], 3840);
        end

        // Saturation both ways
        for (int k = 0; k < TAPS; k++) wcoef(k, 16'sh7FFF);
        clr();
        clearq();
        for (int i = 0; i < 16; i++) send(16'sh7FFF);
        flush();
        chk("satp_count", q4.size(), 4);
        foreach (q4[j]) chk("sat_pos", q4[j], 32767);
        clr();
        clearq();
        for (int i = 0; i < 16; i++) send(-16'sh8000);
        flush();
        chk("satn_count", q4.size(), 4);
        foreach (q4[j]) chk("sat_neg", q4[j], -32768);

        // Rounding with a single half-gain tap
        for (int k = 0; k < TAPS; k++) wcoef(k, (k == 0) ? 16'sh4000 : 16'sh0000);
        clr();
        clearq();
        send(0); send(0); send(0); send(16'sd1);
        send(0); send(0); send(0); send(-16'sd1);
        send(0); send(0); send(0); send(16'sd3);
        flush();
        chk("rnd_count", q4.size(), 3);
        if (q4.size() == 3) begin
            chk("rnd_plus1",  q4[0], 1);
            chk("rnd_minus1", q4[1], 0);
            chk("rnd_plus3",  q4[2], 2);
        end

        // Boxcar with random gaps
        boxcar_coefs();
        clr();
        clearq();
        for (int i = 0; i < 16; i++) begin
            send(16'sh1000);
            repeat ($urandom_range(0, 3)) tick();
        end
        flush();
        chk("gap_count", q4.size(), 4);
        foreach (q4[j]) chk("gap_value", q4[j], 16'h2000);

        // sync_clr mid-frame restarts the phase with empty history
        clearq();
        send(16'sh1000); send(16'sh1000);
        clr();
        send(16'sh1000); send(16'sh1000); send(16'sh1000);
        flush();
        chk("clr_no_early", q4.size(), 0);
        send(16'sh1000);
        flush();
        chk("clr_count", q4.size(), 1);
        if (q4.size() == 1) chk("clr_value", q4[0], 16'h2000);

        // Reset between trigger and output
        clearq();
        for (int i = 0; i < 4; i++) send(16'sh1000);
        reset_n = 1'b0;
        #2;
        model_reset();
        chk("midrst_valid", d4_vld, 0);
        chk("midrst_data",  d4_out, 0);
        reset_n = 1'b1;
        flush();
        chk("midrst_none", q4.size(), 0);
        for (int i = 0; i < 4; i++) send(16'sh1000);
        flush();
        chk("midrst_count", q4.size(), 1);
        if (q4.size() == 1) chk("midrst_zero_coef", q4[0], 0);

        // Coefficient rewrite in the trigger cycle
        boxcar_coefs();
        clearq();
        send(16'sh1000); send(16'sh1000); send(16'sh1000);
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'sh0000;
        send(16'sh1000);
        coef_we = 1'b0;
        for (int i = 0; i < 4; i++) send(16'sh1000);
        flush();
        chk("cw_count", q4.size(), 2);
        if (q4.size() == 2) begin
            chk("cw_old", q4[0], 16'h2000);
            chk("cw_new", q4[1], 16'h1800);
        end

        // Continuous random input: DECIM=1 build outputs every cycle
        for (int k = 0; k < TAPS; k++) wcoef(k, 16'($urandom_range(0, 16'h3FFF)));
        clr();
        clearq();
        for (int i = 0; i < 24; i++) begin
            send(16'($urandom));
            if (i >= 1) chk("d1_every_cycle", d1_vld, 1);
        end
        flush();
        chk("d1_count", q1.size(), 24);

        // Fully random traffic including coefficient writes and clears
        for (int i = 0; i < 400; i++) begin
            data_in   = 16'($urandom);
            valid_in  = ($urandom_range(0, 2) != 0);
            sync_clr  = ($urandom_range(0, 39) == 0);
            coef_we   = ($urandom_range(0, 7) == 0);
            coef_addr = 4'($urandom);
            coef_data = 16'($urandom);
            tick();
        end
        valid_in = 1'b0; sync_clr = 1'b0; coef_we = 1'b0;
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
